// File: rtl/xif_dma_pkg.sv
// xif_dma_pkg: shared types and constants for the xif_dma block-copy initiator.
// Contents: controller state enum, full byte-enable value, word address step.
package xif_dma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam logic [3:0]  BE_FULL   = 4'hF;
  localparam logic [31:0] WORD_STEP = 32'd4;

endpackage

// File: rtl/xif_dma_if.sv
// xif_dma_if: MemSplit32 request/response bus.
// Signals: req/we/addr/be/wdata (initiator -> responder),
//          ack/resp/rdata (responder -> initiator).
// Modports: master (initiator side), slave (responder side).
interface xif_dma_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, resp, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, resp, rdata);
endinterface

// File: rtl/xif_dma_fifo.sv
// xif_dma_fifo: synchronous first-word-fall-through FIFO.
// Ports: clk_i, rst_i (sync, active-high), flush_i (empties the FIFO),
//        push_i/push_data_i, pop_i/pop_data_o, count_o, empty_o.
// DEPTH must be a power of two so the pointers wrap naturally.
module xif_dma_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      push_data_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      pop_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty_o    = (count_o == '0);
  assign full       = (count_o == CNT_W'(DEPTH));
  assign do_pop     = pop_i && !empty_o;
  // A push into a full FIFO is allowed when a pop frees a slot in the same cycle.
  assign do_push    = push_i && (!full || do_pop);
  assign pop_data_o = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_o <= count_o + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/xif_dma.sv
// xif_dma: MemSplit32 initiator copying len_bi words from src to dst.
// Ports: clk_i, rst_i (sync, active-high); start_i/src_addr_bi/dst_addr_bi/
//        len_bi configuration strobe; busy_o, done_o (1-cycle pulse), err_o
//        (sticky timeout); bus (xif_dma_if.master).
// Optional macro XIF_DMA_FILL_EN adds fill_i/fill_data_bi: pattern fill of dst
// with no reads.
module xif_dma
  import xif_dma_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int BUS_TIMEOUT = 1024 * 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] src_addr_bi,
  input  logic [31:0] dst_addr_bi,
  input  logic [15:0] len_bi,
`ifdef XIF_DMA_FILL_EN
  input  logic        fill_i,
  input  logic [31:0] fill_data_bi,
`endif
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  xif_dma_if.master   bus
);
  localparam int          CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int          SUM_W   = CNT_W + 1;
  localparam logic [31:0] TO_LAST = 32'(BUS_TIMEOUT - 1);

  state_e            state;
  logic [31:0]       src_addr;
  logic [31:0]       dst_addr;
  logic [15:0]       rd_left;
  logic [15:0]       wr_left;
  logic [CNT_W-1:0]  outst;
  logic [31:0]       wait_cnt;
  logic              req_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;

  logic              fill_q;
  logic [31:0]       fill_pat_q;
  logic              start_fill;

  logic [31:0]       fifo_dout;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty;

  logic active, handshake, rd_hs, resp_push, can_wr, can_rd;
  logic fifo_pop, pending, bus_event, timeout;

`ifdef XIF_DMA_FILL_EN
  assign start_fill = fill_i;
  always_ff @(posedge clk_i) begin
    if (rst_i)                          fill_q <= 1'b0;
    else if (state == IDLE && start_i) fill_q <= fill_i;
  end
  always_ff @(posedge clk_i) begin
    if (state == IDLE && start_i) fill_pat_q <= fill_data_bi;
  end
`else
  assign start_fill = 1'b0;
  assign fill_q     = 1'b0;
  assign fill_pat_q = '0;
`endif

  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.be    = BE_FULL;
  assign bus.wdata = wdata_q;

  assign active    = (state == RUN) || (state == DRAIN);
  assign handshake = req_q && bus.ack;
  assign rd_hs     = handshake && !we_q;
  // Responses only count while a transfer is live with reads outstanding.
  assign resp_push = active && bus.resp && (outst != '0);
  assign can_wr    = !req_q && (wr_left != '0) && (fill_q || !fifo_empty);
  // Credit check: every outstanding read already owns a FIFO slot.
  assign can_rd    = !req_q && (rd_left != '0) &&
                     ((SUM_W'(fifo_cnt) + SUM_W'(outst)) < SUM_W'(FIFO_DEPTH));
  assign bus_event = handshake || bus.resp;
  assign pending   = req_q || (outst != '0);
  assign timeout   = (BUS_TIMEOUT != 0) && active && pending && !bus_event &&
                     (wait_cnt == TO_LAST);
  // The write word leaves the FIFO when the request is issued and is held in wdata_q.
  assign fifo_pop  = active && can_wr && !fill_q && !timeout;

  xif_dma_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (32)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (timeout),
    .push_i      (resp_push),
    .push_data_i (bus.rdata),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_dout),
    .count_o     (fifo_cnt),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      src_addr <= '0;
      dst_addr <= '0;
      rd_left  <= '0;
      wr_left  <= '0;
      outst    <= '0;
      wait_cnt <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (start_i) begin
            err_o    <= 1'b0;
            src_addr <= src_addr_bi & ~32'h3;
            dst_addr <= dst_addr_bi & ~32'h3;
            outst    <= '0;
            if (len_bi == '0) begin
              state  <= FINISH;
              done_o <= 1'b1;
            end else begin
              state   <= RUN;
              busy_o  <= 1'b1;
              rd_left <= start_fill ? 16'd0 : len_bi;
              wr_left <= len_bi;
            end
          end
        end
        RUN, DRAIN: begin
          if (timeout) begin
            req_q    <= 1'b0;
            err_o    <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            outst    <= '0;
            wait_cnt <= '0;
            state    <= FINISH;
          end else begin
            outst <= outst + CNT_W'(rd_hs) - CNT_W'(resp_push);
            if (bus_event || !pending) wait_cnt <= '0;
            else                       wait_cnt <= wait_cnt + 32'd1;
            if (handshake) begin
              req_q <= 1'b0;
              if (we_q) begin
                wr_left  <= wr_left - 16'd1;
                dst_addr <= dst_addr + WORD_STEP;
              end else begin
                rd_left  <= rd_left - 16'd1;
                src_addr <= src_addr + WORD_STEP;
              end
            end else if (can_wr) begin
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= dst_addr;
              wdata_q <= fill_q ? fill_pat_q : fifo_dout;
            end else if (can_rd) begin
              req_q  <= 1'b1;
              we_q   <= 1'b0;
              addr_q <= src_addr;
            end
            if (state == RUN && rd_left == '0) state <= DRAIN;
            if (state == DRAIN && wr_left == '0) begin
              state  <= FINISH;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xif_dma.sv
// tb_xif_dma: self-checking bench for xif_dma with a randomized-latency
// MemSplit32 responder and a word-level reference model of the copy.
module tb_xif_dma;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy, done, err;
`ifdef XIF_DMA_FILL_EN
  logic        fill;
  logic [31:0] fill_data;
`endif

  xif_dma_if bus_if ();

  xif_dma #(
    .FIFO_DEPTH  (DEPTH),
    .BUS_TIMEOUT (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .src_addr_bi  (src_addr),
    .dst_addr_bi  (dst_addr),
    .len_bi       (len),
`ifdef XIF_DMA_FILL_EN
    .fill_i       (fill),
    .fill_data_bi (fill_data),
`endif
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image and responder knobs (written by the main process only).
  logic [31:0] mem [logic [31:0]];
  int          ack_max   = 0;
  int          resp_max  = 0;
  bit          never_ack = 1'b0;

  // Observations (written by the responder process only).
  typedef struct { logic [31:0] data; int due; } rsp_t;
  rsp_t        rq[$];
  logic [63:0] wlog[$];
  logic [31:0] rlog[$];
  int          cyc = 0, done_cnt = 0, req_cycles = 0, stab_bad = 0, be_bad = 0;
  int          occ = 0, max_occ = 0, dly = 0, last_due = 0;
  bit          req_seen = 1'b0, prev_busy = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic        h_we;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Responder + monitor: decisions are made on the falling edge for the next rising edge.
  initial begin
    bus_if.ack   = 1'b0;
    bus_if.resp  = 1'b0;
    bus_if.rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (busy && !prev_busy) max_occ = 0;
      prev_busy = busy;
      if (!busy) begin
        rq.delete();
        req_seen = 1'b0;
        occ      = 0;
      end
      bus_if.resp = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        bus_if.resp  = 1'b1;
        bus_if.rdata = rq[0].data;
        void'(rq.pop_front());
      end
      bus_if.ack = 1'b0;
      if (bus_if.req) begin
        req_cycles++;
        if (bus_if.be != 4'hF) be_bad++;
        if (!req_seen) begin
          req_seen = 1'b1;
          h_addr   = bus_if.addr;
          h_we     = bus_if.we;
          h_wdata  = bus_if.wdata;
          dly      = $urandom_range(0, ack_max);
        end else if (bus_if.addr !== h_addr || bus_if.we !== h_we ||
                     (h_we && bus_if.wdata !== h_wdata)) begin
          stab_bad++;
        end
        if (!never_ack && dly == 0) begin
          bus_if.ack = 1'b1;
          req_seen   = 1'b0;
          if (h_we) begin
            wlog.push_back({h_addr, h_wdata});
            occ--;
          end else begin
            int due;
            rlog.push_back(h_addr);
            due = cyc + 1 + $urandom_range(0, resp_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rq.push_back('{data: mem[h_addr], due: due});
            occ++;
            if (occ > max_occ) max_occ = occ;
          end
        end else if (dly > 0) begin
          dly--;
        end
      end
    end
  end

  // One transfer against the reference model: word i reads src+4i and writes
  // that word (or the fill pattern) to dst+4i, both with [1:0] cleared.
  task automatic do_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] n, input bit fl, input logic [31:0] pat);
    int          wb, rb, db, rcb, sb, bb, nw, nr;
    bit          got;
    logic [31:0] s0, d0, a;
    wb = wlog.size(); rb = rlog.size(); db = done_cnt; rcb = req_cycles;
    sb = stab_bad; bb = be_bad;
    s0 = src & ~32'h3;
    d0 = dst & ~32'h3;
    for (int i = 0; i < int'(n); i++) begin
      a = s0 + 32'(4 * i);
      mem[a] = $urandom;
    end
    @(negedge clk);
    start = 1'b1; src_addr = src; dst_addr = dst; len = n;
`ifdef XIF_DMA_FILL_EN
    fill = fl; fill_data = pat;
`endif
    @(negedge clk);
    start = 1'b0;
    check({tag, "_err_clr"}, {31'd0, err}, 32'd0);
    if (n == 16'd0) check({tag, "_len0_done"}, {31'd0, done}, 32'd1);
    else            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, 32'(done_cnt - db), 32'd1);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    nw = wlog.size() - wb;
    nr = rlog.size() - rb;
    check({tag, "_nwrites"}, 32'(nw), 32'(n));
    check({tag, "_nreads"}, 32'(nr), fl ? 32'd0 : 32'(n));
    for (int i = 0; i < int'(n) && i < nw; i++) begin
      a = s0 + 32'(4 * i);
      check($sformatf("%s_waddr%0d", tag, i), wlog[wb + i][63:32], d0 + 32'(4 * i));
      check($sformatf("%s_wdata%0d", tag, i), wlog[wb + i][31:0], fl ? pat : mem[a]);
    end
    for (int i = 0; i < int'(n) && i < nr; i++)
      check($sformatf("%s_raddr%0d", tag, i), rlog[rb + i], s0 + 32'(4 * i));
    if (n == 16'd0) check({tag, "_no_req"}, 32'(req_cycles - rcb), 32'd0);
    else            check({tag, "_occ_le_depth"}, {31'd0, max_occ <= DEPTH}, 32'd1);
    check({tag, "_stable"}, 32'(stab_bad - sb), 32'd0);
    check({tag, "_be"}, 32'(be_bad - bb), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_err"},   {31'd0, err}, 32'd0);
    check({tag, "_req"},   {31'd0, bus_if.req}, 32'd0);
    check({tag, "_we"},    {31'd0, bus_if.we}, 32'd0);
    check({tag, "_addr"},  bus_if.addr, 32'd0);
    check({tag, "_wdata"}, bus_if.wdata, 32'd0);
    check({tag, "_be"},    {28'd0, bus_if.be}, 32'hF);
  endtask

  initial begin
    int  n, db, wb;
    bit  got;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
`ifdef XIF_DMA_FILL_EN
    fill = 1'b0; fill_data = '0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Zero-wait responder, plan example.
    ack_max = 0; resp_max = 0;
    do_xfer("zw", 32'h100, 32'h200, 16'd4, 1'b0, 32'd0);
    do_xfer("len0", 32'h100, 32'h200, 16'd0, 1'b0, 32'd0);

    // Random latency, unaligned source/destination bits ignored.
    ack_max = 5; resp_max = 5;
    do_xfer("rnd1", 32'h1003, 32'h8002, 16'd20, 1'b0, 32'd0);
    do_xfer("rnd2", {$urandom} & 32'hFFFF_FF00, 32'h4000_0000, 16'd20, 1'b0, 32'd0);

    // Source range wraps through address zero.
    ack_max = 1; resp_max = 2;
    do_xfer("wrap", 32'hFFFF_FFF8, 32'h300, 16'd4, 1'b0, 32'd0);

    // Responder never acks: abort after 16 cycles of pending request.
    never_ack = 1'b1;
    @(negedge clk);
    start = 1'b1; src_addr = 32'h100; dst_addr = 32'h200; len = 16'd4;
    @(negedge clk);
    start = 1'b0;
    db = done_cnt;
    for (int k = 0; k < 20 && !bus_if.req; k++) @(negedge clk);
    n = 0;
    while (bus_if.req && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("to_req_cycles", 32'(n), 32'd16);
    check("to_done", {31'd0, done}, 32'd1);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("to_done_once", 32'(done_cnt - db), 32'd1);
    check("to_err_sticky", {31'd0, err}, 32'd1);
    never_ack = 1'b0;
    ack_max = 2; resp_max = 3;
    do_xfer("after_to", 32'h600, 32'h700, 16'd5, 1'b0, 32'd0);

    // Reset in the middle of an 8-word copy.
    db = done_cnt; wb = wlog.size();
    for (int i = 0; i < 8; i++) mem[32'h400 + 32'(4 * i)] = $urandom;
    @(negedge clk);
    start = 1'b1; src_addr = 32'h400; dst_addr = 32'h500; len = 16'd8;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (wlog.size() - wb >= 2) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("rst_mid_reached", {31'd0, got}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_no_done", 32'(done_cnt - db), 32'd0);
    do_xfer("after_rst", 32'h900, 32'hA00, 16'd6, 1'b0, 32'd0);

`ifdef XIF_DMA_FILL_EN
    do_xfer("fill", 32'h100, 32'hB00, 16'd3, 1'b1, 32'hDEAD_BEEF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xif_dma.md
Name: xif_dma

Overview:
- MemSplit32 bus initiator that copies a block of 32-bit words from a source address range to a destination address range.
- Drives the request side of a MemSplit32 port: req/we/addr/be/wdata out; ack/resp/rdata in.
- Attached to a tile's external/host bus alongside CSR-style responders.
- Configured by a simple start/length/address strobe interface, normally driven from a CSR block.
- Words are buffered in a small internal FIFO so reads and writes overlap.

Parameters:
- FIFO_DEPTH, 4, data FIFO entries; power of 2, range 2..16.
- BUS_TIMEOUT, 1024*1024, cycles to wait for ack or read resp before aborting; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle start strobe; ignored while busy_o=1
- src_addr_bi  in  32  source byte address, sampled on start; bits [1:0] ignored
- dst_addr_bi  in  32  destination byte address, sampled on start; bits [1:0] ignored
- len_bi  in  16  transfer length in words, sampled on start
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse on completion or abort
- err_o  out  1  sticky timeout flag; cleared on the next accepted start
- bus_req_o  out  1  request valid
- bus_we_o  out  1  1=write, 0=read
- bus_addr_bo  out  32  word-aligned byte address
- bus_be_bo  out  4  byte enables; always 4'hF
- bus_wdata_bo  out  32  write data
- bus_ack_i  in  1  request accepted when bus_req_o & bus_ack_i
- bus_resp_i  in  1  read data valid
- bus_rdata_bi  in  32  read data

Behaviour:
- Reset: busy_o=0, done_o=0, err_o=0, bus_req_o=0, bus_we_o=0, bus_addr_bo=0, bus_wdata_bo=0, bus_be_bo=4'hF. FIFO is emptied and all counters cleared.
- Reset asserted mid-transfer aborts immediately. No done_o pulse. Outstanding responses that arrive after reset are ignored.
- States: IDLE, RUN, DRAIN, FINISH.
- IDLE, start_i=1, len_bi!=0:
  - Latch addresses with [1:0] forced to 0.
  - Set rd_left = wr_left = len_bi; clear err_o.
  - Go to RUN; busy_o=1 from the next cycle.
- IDLE, start_i=1, len_bi=0: go straight to FINISH with no bus traffic; done_o pulses 1 cycle after start.
- Request hold rule: once bus_req_o rises, addr/we/wdata stay stable until the handshake cycle. A pending request is never withdrawn except by reset or timeout abort.
- Request selection, evaluated only when no request is pending:
  - Write is issued if the FIFO is non-empty and wr_left!=0.
  - Otherwise read is issued if rd_left!=0 and (FIFO count + outstanding reads) < FIFO_DEPTH.
  - Writes have priority. The credit check guarantees every response has a FIFO slot.
- Addresses increment by 4 after each accepted read/write, wrapping modulo 2^32.
- Read responses arrive in order. Each bus_resp_i pushes bus_rdata_bi into the FIFO and decrements the outstanding count.
- Simultaneous events:
  - A resp and a write pop in the same cycle are both honoured; count is unchanged.
  - A read accept and a resp in the same cycle leave the outstanding count unchanged.
- Handshake latency: a new request may be presented the cycle after an ack, giving at most 1 handshake per 2 cycles per direction. Full-rate back-to-back issue is not required.
- RUN moves to DRAIN when rd_left=0. DRAIN moves to FINISH when wr_left=0.
- FINISH: done_o=1 for exactly one cycle, busy_o falls in the same cycle, then back to IDLE.
- Writes produce no response; completion of a write is its ack.
- Timeout: a wait counter counts while a request is pending un-acked, or while reads are outstanding and no resp arrives. It resets on any handshake or resp. On reaching BUS_TIMEOUT:
  - bus_req_o drops and the FIFO is flushed.
  - err_o=1 and the state goes to FINISH, so done_o still pulses.

Optional Feature:
- Macro XIF_DMA_FILL_EN.
- Defined:
  - Extra ports fill_i (1 bit, sampled on start) and fill_data_bi (32 bits, sampled on start).
  - With fill_i=1, no reads are issued; len_bi writes of the latched pattern go to dst, and rd_left is treated as 0.
- Undefined: the ports are absent and the block behaves as a pure copy engine.

Decomposition:
- Package xif_dma_pkg holds:
  - the state enum typedef (IDLE/RUN/DRAIN/FINISH);
  - BE_FULL = 4'hF;
  - WORD_STEP = 32'd4.
- Sub-module xif_dma_fifo: synchronous FIFO parameterised by depth and width, with push/pop/flush/count/empty outputs. It is reusable for other initiators.

Test Plan:
- Zero-wait responder (ack=req, resp 1 cycle later); src=0x100, dst=0x200, len=4, memory 0x100..0x10C = 1,2,3,4 → writes 1,2,3,4 to 0x200..0x20C with be=4'hF, done_o pulses once, err_o=0.
- len=0 → no bus_req_o ever, done_o pulses 1 cycle after start.
- Responder with random 0–5 cycle ack and resp delays; len=20; FIFO_DEPTH=4 → data correct, outstanding reads + FIFO count never exceed 4, addr/wdata stable while req is un-acked.
- src=0xFFFFFFF8, len=4 → read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- BUS_TIMEOUT=16, responder never acks → bus_req_o drops after 16 cycles, err_o=1, done_o pulses; the next start clears err_o.
- rst_i asserted mid-transfer (after 2 of 8 words) → all outputs return to reset values the next cycle, no done_o pulse; with XIF_DMA_FILL_EN, fill_i=1, fill_data_bi=0xDEADBEEF, len=3 → three writes of 0xDEADBEEF and no reads.
